// File: rtl/omem.sv
// ============================================================================
// omem : output-side bank memory with a byte-serial valid/ready streamer
// Revision: 1.0
// ============================================================================
`default_nettype none

module omem #(
  parameter int NBANK  = 4,
  parameter int WBYTES = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [$clog2(NBANK)-1:0]   waddr,
  input  logic [8*WBYTES-1:0]        wdata,
  input  logic                       wr,
  input  logic                       start,
  input  logic [$clog2(NBANK)-1:0]   sbank,
  input  logic [$clog2(NBANK)-1:0]   nbank,
  output logic [7:0]                 odata,
  output logic                       ovalid,
  input  logic                       oready,
  output logic                       busy,
  output logic                       done
);

  localparam int c_AW = $clog2(NBANK);
  localparam int c_CW = $clog2(WBYTES);
  localparam int c_DW = 8 * WBYTES;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [c_DW-1:0]   r_mem [NBANK];
  logic [c_DW-1:0]   r_shreg;
  logic [c_CW-1:0]   r_bcnt;
  logic [c_AW-1:0]   r_cur_bank;
  logic [c_AW-1:0]   r_left;
  logic              w_accept;
  logic              w_last_byte;

  // Write port runs independently of the streamer and is never cleared.
  always_ff @(posedge clock) begin
    if (wr) begin
      r_mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_bcnt     <= '0;
      r_cur_bank <= '0;
      r_left     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cur_bank <= sbank;
            r_left     <= nbank;
          end
        end
        S_LOAD: begin
          // Non-blocking read sees the word as it was before a same-edge write.
          r_shreg <= r_mem[r_cur_bank];
          r_bcnt  <= '0;
        end
        S_SEND: begin
          if (w_accept) begin
            r_shreg <= r_shreg >> 8;
            r_bcnt  <= r_bcnt + c_CW'(1);
            if (w_last_byte && (r_left != '0)) begin
              r_cur_bank <= r_cur_bank + c_AW'(1);
              r_left     <= r_left - c_AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_last_byte = (r_bcnt == c_LAST);
    odata       = '0;
    ovalid      = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_next = S_SEND;
      end
      S_SEND: begin
        ovalid   = 1'b1;
        odata    = r_shreg[7:0];
        w_accept = oready;
        if (w_accept && w_last_byte) begin
          w_next = (r_left == '0) ? S_DONE : S_LOAD;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_omem.sv
// ============================================================================
// tb_omem : table-driven and randomized bench for omem against a byte-queue model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_omem;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   waddr;
  logic [255:0] wdata;
  logic         wr;
  logic         start;
  logic [1:0]   sbank;
  logic [1:0]   nbank;
  logic [7:0]   odata;
  logic         ovalid;
  logic         oready;
  logic         busy;
  logic         done;

  omem dut (
    .clock  (clock),
    .reset  (reset),
    .waddr  (waddr),
    .wdata  (wdata),
    .wr     (wr),
    .start  (start),
    .sbank  (sbank),
    .nbank  (nbank),
    .odata  (odata),
    .ovalid (ovalid),
    .oready (oready),
    .busy   (busy),
    .done   (done)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference memory: four banks of 32 bytes.
  logic [7:0] mm [4][32];

  typedef struct {
    int         sb;
    int         nb;
    int         pct;
    int         wr_at;
    logic [7:0] wd;
    int         restart_at;
    int         abort_after;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_bank(input int b, input logic [255:0] d);
    waddr = 2'(b);
    wdata = d;
    wr    = 1'b1;
    step();
    wr    = 1'b0;
    for (int k = 0; k < 32; k++) mm[b][k] = d[8*k +: 8];
  endtask

  task automatic run_stream(input vec_t v);
    logic [7:0] q[$];
    int idx, rel, first, bubbles;
    bit stalled, seen_done, acc;
    logic [7:0] prev;
    logic [255:0] fill;
    for (int i = 0; i <= v.nb; i++)
      for (int k = 0; k < 32; k++) q.push_back(mm[(v.sb + i) % 4][k]);
    idx = 0; rel = 0; first = -1; bubbles = 0; stalled = 0; seen_done = 0; prev = '0;
    for (int k = 0; k < 32; k++) fill[8*k +: 8] = v.wd;

    sbank  = 2'(v.sb);
    nbank  = 2'(v.nb);
    oready = 1'b0;
    start  = 1'b1;
    step();
    start  = 1'b0;
    check("load_ovalid", ovalid, 0);
    check("load_busy", busy, 1);

    while (rel < 3000) begin
      wr = (rel == v.wr_at);
      if (wr) begin
        waddr = 2'd2;
        wdata = fill;
        for (int k = 0; k < 32; k++) mm[2][k] = v.wd;
      end
      if (rel == v.restart_at) begin
        start = 1'b1;
        sbank = 2'(v.sb + 2);
        nbank = 2'(v.nb + 1);
      end else begin
        start = 1'b0;
      end
      oready = (v.pct >= 100) ? 1'b1 : ($urandom_range(99) < v.pct);
      if (ovalid && idx == v.abort_after) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        wr = 1'b0;
        check("abort_ovalid", ovalid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        acc = 0;
        for (int c = 0; c < 40; c++) begin
          step();
          if (done) acc = 1;
        end
        check("abort_no_done", acc, 0);
        return;
      end
      acc     = ovalid && oready;
      stalled = ovalid && !oready;
      prev    = odata;
      if (acc) idx++;
      step();
      rel++;

      if (done) begin
        seen_done = 1;
        check("done_count", idx, q.size());
        if (v.pct >= 100 && v.restart_at < 0) begin
          check("done_latency", rel, q.size() + v.nb + 1);
          check("first_valid", first, 1);
          check("bubbles", bubbles, v.nb);
        end
        start = 1'b0;
        wr    = 1'b0;
        step();
        check("done_pulse_len", done, 0);
        check("busy_after_done", busy, 0);
        break;
      end
      check("busy_mid", busy, 1);
      if (ovalid) begin
        if (first < 0) first = rel;
        if (stalled) check("stall_stable", odata, prev);
        if (idx < q.size()) check("byte", odata, q[idx]);
        else check("extra_byte", 1, 0);
      end else if (first >= 0) begin
        bubbles++;
      end
    end
    wr = 1'b0;
    start = 1'b0;
    if (!seen_done) check("done_timeout", 0, 1);
  endtask

  vec_t vt [9];
  vec_t rv;
  logic [255:0] d;

  initial begin
    reset = 1'b1; wr = 1'b0; start = 1'b0; oready = 1'b0;
    waddr = '0; wdata = '0; sbank = '0; nbank = '0;
    repeat (3) step();
    check("rst_ovalid", ovalid, 0);
    check("rst_odata", odata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    step();

    // Bank 1 with ascending bytes, single-bank stream.
    for (int k = 0; k < 32; k++) d[8*k +: 8] = 8'(k);
    write_bank(1, d);
    run_stream('{1, 0, 100, -1, 8'h00, -1, -1});

    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 32; k++) d[8*k +: 8] = 8'(8'h40 * b + k);
      write_bank(b, d);
    end

    vt[0] = '{3, 1, 100, -1, 8'h00, -1, -1};   // wrap 3 -> 0
    vt[1] = '{0, 3, 100, -1, 8'h00, -1, -1};   // full 4-bank stream
    vt[2] = '{0, 3, 50,  -1, 8'h00, -1, -1};   // random stalls
    vt[3] = '{2, 0, 100,  0, 8'hFF, -1, -1};   // write in LOAD cycle
    vt[4] = '{2, 0, 100, -1, 8'h00, -1, -1};   // sees 0xFF
    vt[5] = '{2, 0, 100, 10, 8'h5A, -1, -1};   // write mid-SEND
    vt[6] = '{2, 0, 100, -1, 8'h00, -1, -1};   // sees 0x5A
    vt[7] = '{1, 2, 100, -1, 8'h00,  5, -1};   // start while busy
    vt[8] = '{0, 3, 100, -1, 8'h00, -1, 10};   // reset at byte 10
    for (int i = 0; i < 9; i++) run_stream(vt[i]);

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
      write_bank(int'($urandom_range(3)), d);
      rv = '{int'($urandom_range(3)), int'($urandom_range(3)),
             int'($urandom_range(100, 20)), -1, 8'h00, -1, -1};
      run_stream(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
